popsum_sequencer: RTL and testbench
===================================

POPSUM_SEQUENCER -- requirements
Module: popsum_sequencer

Interface
REQ-001 The block SHALL take parameter NUM_CHUNKS, default 4: maximum 36-bit operand beats per vector.
REQ-002 The block SHALL take parameter ACC_W, default 9: accumulator and out_sum width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: beat accepted when in_valid and in_ready are both 1.
REQ-008 The block SHALL have port in_op, input, 36 bits: twelve 3-bit operands, op k at [3k+2:3k].
REQ-009 The block SHALL have port in_last, input, 1 bit: beat is the final chunk of the vector.
REQ-010 The block SHALL have port threshold, input, ACC_W bits: firing threshold.
REQ-011 The block SHALL have port tree_op, output, 36 bits: registered operands to the external 12-input 3-bit Wallace tree.
REQ-012 The block SHALL have port tree_res, input, 7 bits: combinational tree sum of tree_op, 0..84.
REQ-013 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit) forming the result handshake.
REQ-014 The block SHALL have ports out_sum (output, ACC_W bits), out_fire (output, 1 bit) and out_ovf (output, 1 bit).

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, DRAIN and HOLD.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in DRAIN and HOLD.
REQ-017 On acceptance, tree_op SHALL load in_op at that edge; on the next edge the accumulator SHALL add tree_res zero-extended to ACC_W.
REQ-018 For the first beat of a vector, the accumulator SHALL load tree_res instead of adding it, and threshold SHALL be captured.
REQ-019 IDLE SHALL go to ACCUM on an accepted non-final beat, and to DRAIN on an accepted final beat.
REQ-020 A beat SHALL be final when in_last=1 or when it is beat number NUM_CHUNKS of the vector, whichever comes first.
REQ-021 ACCUM SHALL accept back-to-back beats (1 beat/cycle) and go to DRAIN on a final beat.
REQ-022 DRAIN SHALL last exactly one cycle, add the last tree_res, register out_sum, out_fire and out_ovf, and go to HOLD.
REQ-023 out_valid SHALL be 1 exactly in HOLD, i.e. 2 edges after the final-beat acceptance edge.
REQ-024 out_fire SHALL equal (final sum >= captured threshold), compared unsigned.
REQ-025 out_sum, out_fire and out_ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid=1 with out_ready=1 SHALL go to IDLE, with in_ready=1 on the following cycle.
REQ-027 in_valid SHALL be ignored in DRAIN and HOLD: no beat is consumed and tree_op is unchanged.
REQ-028 tree_op SHALL hold its last value when no beat is accepted.

Reset
REQ-029 rst_n low SHALL force IDLE and clear the accumulator, beat count, tree_op, out_valid, out_sum, out_fire and out_ovf to 0, with in_ready=1, regardless of state.
REQ-030 Reset mid-vector SHALL discard the partial sum; no result for that vector SHALL ever be presented.

Configuration
REQ-031 With macro POPSUM_SAT_EN defined, an accumulate exceeding 2^ACC_W-1 SHALL clamp to 2^ACC_W-1 and set out_ovf for that vector.
REQ-032 With POPSUM_SAT_EN undefined, the accumulator SHALL wrap modulo 2^ACC_W, and out_ovf SHALL still flag the carry-out and never affect out_sum.

Verification
REQ-033 The bench SHALL apply one beat, in_op=36'hFFFFFFFFF, in_last=1, threshold=80 -> tree_op=36'hFFFFFFFFF, out_valid after 2 edges, out_sum=84, out_fire=1, out_ovf=0.
REQ-034 The bench SHALL apply four back-to-back all-ones beats, in_last on beat 4, threshold=337 -> out_sum=336, out_fire=0, in_ready=0 from the cycle after beat 4.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles while driving in_valid=1 -> outputs stable, tree_op unchanged, no beat consumed, and IDLE one cycle after out_ready=1.
REQ-036 The bench SHALL assert rst_n=0 after 2 of 4 beats, then run a single beat of operand value 1 in every field -> out_sum=12, with no stale result presented.
REQ-037 The bench SHALL run ACC_W=8 with four all-ones beats -> out_sum=255 and out_ovf=1 with POPSUM_SAT_EN; out_sum=80 and out_ovf=1 without it.
REQ-038 The bench SHALL run NUM_CHUNKS=2 with in_last held 0 and two all-ones beats -> out_sum=168, and in_ready=0 after beat 2.

Source files
------------

// File: rtl/popsum_sequencer.sv
// Chunked popcount-sum sequencer: feeds 36-bit beats to an external 12x3-bit
// Wallace tree, accumulates the tree sums and compares against a threshold.
// Optional macro POPSUM_SAT_EN: saturate the accumulator instead of wrapping.
module popsum_sequencer #(
  parameter int NUM_CHUNKS = 4,
  parameter int ACC_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [35:0]      in_op,
  input  logic             in_last,
  input  logic [ACC_W-1:0] threshold,
  output logic [35:0]      tree_op,
  input  logic [6:0]       tree_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_fire,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(NUM_CHUNKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] thr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             pend_r;
  logic             first_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic [35:0]      tree_op_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic             out_fire_r;
  logic             out_ovf_r;

  logic             accept_s;
  logic             final_s;
  logic [ACC_W-1:0] res_ext_s;
  logic [ACC_W:0]   sum_wide_s;
  logic [ACC_W-1:0] next_acc_s;
  logic             next_ovf_s;

  assign accept_s  = in_valid && in_ready_r;
  assign final_s   = in_last || (cnt_r == CNT_W'(NUM_CHUNKS - 1));
  assign res_ext_s = ACC_W'(tree_res);

  // Tree result arrives one cycle after its beat; the first beat of a vector loads rather than adds.
  always_comb begin
    sum_wide_s = {1'b0, res_ext_s};
    if (!first_r) begin
      sum_wide_s = {1'b0, acc_r} + {1'b0, res_ext_s};
    end else begin
      sum_wide_s = {1'b0, res_ext_s};
    end
    next_ovf_s = sum_wide_s[ACC_W] | (first_r ? 1'b0 : ovf_r);
`ifdef POPSUM_SAT_EN
    next_acc_s = sum_wide_s[ACC_W] ? {ACC_W{1'b1}} : sum_wide_s[ACC_W-1:0];
`else
    next_acc_s = sum_wide_s[ACC_W-1:0];
`endif
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      acc_r       <= '0;
      thr_r       <= '0;
      cnt_r       <= '0;
      pend_r      <= 1'b0;
      first_r     <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      tree_op_r   <= 36'd0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_fire_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else begin
      pend_r  <= accept_s;
      first_r <= accept_s && (cnt_r == '0);
      if (pend_r) begin
        acc_r <= next_acc_s;
        ovf_r <= next_ovf_s;
      end
      if (accept_s) begin
        tree_op_r <= in_op;
        cnt_r     <= final_s ? '0 : cnt_r + CNT_W'(1);
        if (cnt_r == '0) begin
          thr_r <= threshold;
        end
      end
      case (state_r)
        S_IDLE, S_ACCUM: begin
          if (accept_s) begin
            state_r    <= final_s ? S_DRAIN : S_ACCUM;
            in_ready_r <= !final_s;
          end
        end
        S_DRAIN: begin
          out_sum_r   <= next_acc_s;
          out_fire_r  <= (next_acc_s >= thr_r);
          out_ovf_r   <= next_ovf_s;
          out_valid_r <= 1'b1;
          state_r     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign tree_op   = tree_op_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_fire  = out_fire_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_popsum_sequencer.sv
// Directed scoreboard bench for popsum_sequencer: three instances (default,
// ACC_W=8, NUM_CHUNKS=2), each with a behavioural Wallace tree model.
module tb_popsum_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [35:0] in_op = 36'd0;
  logic        in_last = 1'b0;
  logic [8:0]  thr = 9'd0;
  logic        out_ready = 1'b0;
  int          cur = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [8:0] sum;
    logic       fire;
    logic       ovf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] tsum(input logic [35:0] v);
    logic [6:0] s;
    s = 7'd0;
    for (int k = 0; k < 12; k++) s = s + 7'(v[3*k +: 3]);
    return s;
  endfunction

  logic        iv0, ir0, ov0, of0, oo0;
  logic [35:0] to0;
  logic [6:0]  tr0;
  logic [8:0]  os0;
  logic        iv1, ir1, ov1, of1, oo1;
  logic [35:0] to1;
  logic [6:0]  tr1;
  logic [7:0]  os1;
  logic        iv2, ir2, ov2, of2, oo2;
  logic [35:0] to2;
  logic [6:0]  tr2;
  logic [8:0]  os2;

  assign iv0 = in_valid && (cur == 0);
  assign iv1 = in_valid && (cur == 1);
  assign iv2 = in_valid && (cur == 2);
  assign tr0 = tsum(to0);
  assign tr1 = tsum(to1);
  assign tr2 = tsum(to2);

  popsum_sequencer #(.NUM_CHUNKS(4), .ACC_W(9)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_op(in_op),
    .in_last(in_last), .threshold(thr), .tree_op(to0), .tree_res(tr0),
    .out_valid(ov0), .out_ready(out_ready), .out_sum(os0), .out_fire(of0), .out_ovf(oo0));

  popsum_sequencer #(.NUM_CHUNKS(4), .ACC_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_op(in_op),
    .in_last(in_last), .threshold(thr[7:0]), .tree_op(to1), .tree_res(tr1),
    .out_valid(ov1), .out_ready(out_ready), .out_sum(os1), .out_fire(of1), .out_ovf(oo1));

  popsum_sequencer #(.NUM_CHUNKS(2), .ACC_W(9)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_op(in_op),
    .in_last(in_last), .threshold(thr), .tree_op(to2), .tree_res(tr2),
    .out_valid(ov2), .out_ready(out_ready), .out_sum(os2), .out_fire(of2), .out_ovf(oo2));

  logic        c_ir, c_ov, c_of, c_oo;
  logic [35:0] c_to;
  logic [8:0]  c_os;

  // View of whichever instance the current step targets.
  always_comb begin
    c_ir = ir0; c_ov = ov0; c_of = of0; c_oo = oo0; c_to = to0; c_os = os0;
    case (cur)
      1: begin c_ir = ir1; c_ov = ov1; c_of = of1; c_oo = oo1; c_to = to1; c_os = {1'b0, os1}; end
      2: begin c_ir = ir2; c_ov = ov2; c_of = of2; c_oo = oo2; c_to = to2; c_os = os2; end
      default: begin c_ir = ir0; c_ov = ov0; c_of = of0; c_oo = oo0; c_to = to0; c_os = os0; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [8:0] s, input logic f, input logic o);
    exp_t e;
    e.sum = s; e.fire = f; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard, then handshake.
  task automatic collect(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!c_ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(c_ov), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 64'(c_os), 64'(e.sum));
      chk({tag, "_fire"}, 64'(c_of), 64'(e.fire));
      chk({tag, "_ovf"}, 64'(c_oo), 64'(e.ovf));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 64'(c_ir), 64'd1);
    chk({tag, "_idle_valid"}, 64'(c_ov), 64'd0);
  endtask

  localparam logic [35:0] ONES = 36'hFFFFFFFFF;
  localparam logic [35:0] UNIT = 36'h249249249;

  initial begin
    logic [63:0] rnd;
    logic [35:0] ops [3];
    logic [8:0]  s;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 64'({ir0, ir1, ir2}), 64'h7);
    chk("rst_valid", 64'({ov0, ov1, ov2}), 64'h0);
    chk("rst_tree_op", 64'(to0), 64'd0);
    chk("rst_outs", 64'({os0, of0, oo0}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single final beat, all ones
    cur = 0;
    in_valid = 1'b1; in_op = ONES; in_last = 1'b1; thr = 9'd80;
    push(9'd84, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("one_tree_op", 64'(c_to), 64'(ONES));
    chk("one_valid_early", 64'(c_ov), 64'd0);
    chk("one_ready_drain", 64'(c_ir), 64'd0);
    @(negedge clk);
    chk("one_valid_2edges", 64'(c_ov), 64'd1);
    collect("one");

    // Four back-to-back beats, then hold out_ready low with in_valid driven
    thr = 9'd337;
    for (int b = 0; b < 4; b++) begin
      chk("b2b_ready", 64'(c_ir), 64'd1);
      in_valid = 1'b1; in_op = ONES; in_last = (b == 3);
      @(negedge clk);
    end
    push(9'd336, 1'b0, 1'b0);
    chk("b2b_ready_after4", 64'(c_ir), 64'd0);
    in_op = 36'h123456789; in_last = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", 64'(c_ov), 64'd1);
      chk("hold_sum", 64'(c_os), 64'd336);
      chk("hold_tree_op", 64'(c_to), 64'(ONES));
      chk("hold_ready", 64'(c_ir), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect("b2b");

    // Three random beats
    s = 9'd0;
    for (int b = 0; b < 3; b++) begin
      rnd = {$urandom, $urandom};
      ops[b] = rnd[35:0];
      s = s + 9'(tsum(ops[b]));
    end
    thr = 9'd100;
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1; in_op = ops[b]; in_last = (b == 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    push(s, s >= 9'd100, 1'b0);
    collect("rand");

    // Reset mid-vector, then one beat of ones in every field
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_op = ONES; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(c_ir), 64'd1);
    chk("mid_rst_tree_op", 64'(c_to), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_op = UNIT; in_last = 1'b1; thr = 9'd12;
    push(9'd12, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    collect("post_rst");
    repeat (4) @(negedge clk);
    chk("no_stale_valid", 64'(c_ov), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // ACC_W=8 overflow with four all-ones beats
    cur = 1;
    thr = 9'd100;
    for (int b = 0; b < 4; b++) begin
      in_valid = 1'b1; in_op = ONES; in_last = (b == 3);
      @(negedge clk);
    end
    in_valid = 1'b0;
`ifdef POPSUM_SAT_EN
    push(9'd255, 1'b1, 1'b1);
`else
    push(9'd80, 1'b0, 1'b1);
`endif
    collect("ovf8");

    // NUM_CHUNKS=2 forces the final beat without in_last
    cur = 2;
    thr = 9'd168;
    in_valid = 1'b1; in_op = ONES; in_last = 1'b0;
    @(negedge clk);
    chk("nc2_ready_b1", 64'(c_ir), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("nc2_ready_b2", 64'(c_ir), 64'd0);
    push(9'd168, 1'b1, 1'b0);
    collect("nc2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
